dram_read_arbiter: RTL and testbench
====================================

// Module: dram_read_arbiter
// PURPOSE
//  Shares the single DRAM read command/data channel among NUM_REQ pulse-driven requesters (req 0 = image sender, req 1 = capture/DMA).
//  Buffers one pending request per requester and grants round-robin.
//  Keeps exactly one burst in flight and routes returned beats only to the owning requester.
//  Sits between requester dram_read_* ports and the AXI read master.
// PARAMETERS
//  NUM_REQ          2    number of requesters (2..8)
//  AXI_ADDR_WIDTH   32   byte address width
//  DRAM_DATA_WIDTH  512  read beat width
// PORTS
//  clk_pixel             in   1                        single clock
//  dram_arbiter_reset    in   1                        asynchronous, active-high reset
//  req_read_en           in   NUM_REQ                  per-requester 1-cycle request pulse
//  req_read_addr         in   NUM_REQ*AXI_ADDR_WIDTH   per-requester byte addr, slice i = requester i
//  req_read_len          in   NUM_REQ*8                per-requester AXI len (beats-1)
//  req_read_busy         out  NUM_REQ                  request slot full or burst owned
//  req_read_data_valid   out  NUM_REQ                  one-hot beat strobe to owner
//  req_read_data         out  DRAM_DATA_WIDTH          beat data, broadcast to all
//  dram_read_addr        out  AXI_ADDR_WIDTH           to AXI master
//  dram_read_len         out  8                        to AXI master
//  dram_read_en          out  1                        1-cycle command pulse
//  dram_read_busy        in   1                        master cannot accept a command
//  dram_read_data        in   DRAM_DATA_WIDTH          from master
//  dram_read_data_valid  in   1                        from master
//  arb_error             out  NUM_REQ+1                sticky: [i] overflow of req i, [NUM_REQ] stray beat
// BEHAVIOUR
//  Reset: all outputs 0; slots empty; state IDLE; rr_ptr=0; beat_cnt=0; arb_error=0. Reset mid-burst abandons the burst.
//  Slot i: req_read_en[i] with slot empty -> addr/len captured at that edge, slot valid next cycle.
//   With slot full -> request dropped and arb_error[i] set.
//  req_read_busy[i] = slot_valid[i] | (state!=IDLE && owner==i). Combinational, no extra delay.
//  FSM IDLE: any slot valid -> pick first valid slot at or after rr_ptr (wrapping); latch owner/addr/len; go ISSUE.
//  FSM ISSUE: when !dram_read_busy -> dram_read_en=1 for exactly 1 cycle with latched addr/len.
//   Clear slot[owner]; beat_cnt=0; go WAIT_DATA. Otherwise hold ISSUE, addr/len stable.
//  FSM WAIT_DATA: each dram_read_data_valid -> req_read_data_valid[owner]=1, same cycle, combinational pass-through.
//   Data passes through unregistered. beat_cnt counts beats.
//   On beat with beat_cnt==len -> rr_ptr=owner+1 (mod NUM_REQ); go IDLE.
//  Minimum latency: req pulse at edge N -> dram_read_en high in cycle after edge N+2 (IDLE, ISSUE).
//  Back-to-back: the next grant is evaluated in the IDLE cycle after the last beat.
//   One idle cycle between bursts is required.
//  dram_read_data_valid outside WAIT_DATA: beat dropped, no strobe, arb_error[NUM_REQ] set.
//  A requester may re-request while its burst is in flight (slot empty); it queues normally.
//  Simultaneous pulses: all captured; grant order is round-robin from rr_ptr.
//  beat_cnt is 8 bit, compared to len; len=255 -> 256 beats, no wrap issue.
//  arb_error bits clear only on reset.
// STRUCTURE
//  Package dram_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_DATA} arb_state_t;
//   also ARB_LEN_WIDTH=8 and the rr next-index function.
//  Sub-module dram_req_slot (one-deep holding register + overflow flag), instanced NUM_REQ times via generate.
//  Top holds the FSM, round-robin pointer, beat counter and data router.
// TESTING
//  Single req0 addr=0x1000 len=0, master idle -> dram_read_en 2 cycles later, addr 0x1000;
//   1 beat -> req_read_data_valid=2'b01; busy[0] drops after the beat.
//  req0 and req1 pulse same cycle, rr_ptr=0 -> req0 issued first, req1 next.
//   Two more simultaneous pairs -> grants alternate 0,1,0,1.
//  dram_read_busy held high 10 cycles during ISSUE -> one dram_read_en pulse only, after busy falls;
//   addr/len stable throughout.
//  req1 len=3 -> exactly 4 strobes on bit 1, none on bit 0; state IDLE after the 4th beat.
//  Second req0 pulse while slot0 full -> dropped, arb_error[0]=1, no extra command issued.
//  Assert reset mid WAIT_DATA, then inject 2 beats -> no strobes, arb_error[NUM_REQ]=1;
//   outputs 0 during reset.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM read arbiter.
package dram_arb_pkg;

  localparam int unsigned ARB_LEN_WIDTH = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_DATA} arb_state_t;

  // Next requester index after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dram_req_slot.sv
// One-deep holding register for a single requester's read command, with sticky overflow.
module dram_req_slot
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [ARB_LEN_WIDTH-1:0] len,
  input  logic                     clr,
  output logic                     valid,
  output logic [ADDR_W-1:0]        held_addr,
  output logic [ARB_LEN_WIDTH-1:0] held_len,
  output logic                     overflow
);

  // A request arriving on the same edge the slot is drained is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      held_addr <= '0;
      held_len  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (en && (!valid || clr)) begin
        valid     <= 1'b1;
        held_addr <= addr;
        held_len  <= len;
      end else if (clr) begin
        valid <= 1'b0;
      end
      if (en && valid && !clr) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read channel among NUM_REQ requesters,
// one burst in flight, returned beats routed to the owning requester.
module dram_read_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned DRAM_DATA_WIDTH = 512
) (
  input  logic                                clk_pixel,
  input  logic                                dram_arbiter_reset,
  input  logic [NUM_REQ-1:0]                  req_read_en,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_read_addr,
  input  logic [NUM_REQ*ARB_LEN_WIDTH-1:0]    req_read_len,
  output logic [NUM_REQ-1:0]                  req_read_busy,
  output logic [NUM_REQ-1:0]                  req_read_data_valid,
  output logic [DRAM_DATA_WIDTH-1:0]          req_read_data,
  output logic [AXI_ADDR_WIDTH-1:0]           dram_read_addr,
  output logic [ARB_LEN_WIDTH-1:0]            dram_read_len,
  output logic                                dram_read_en,
  input  logic                                dram_read_busy,
  input  logic [DRAM_DATA_WIDTH-1:0]          dram_read_data,
  input  logic                                dram_read_data_valid,
  output logic [NUM_REQ:0]                    arb_error
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t               state;
  logic [IDX_W-1:0]         owner;
  logic [IDX_W-1:0]         rr_ptr;
  logic [ARB_LEN_WIDTH-1:0] beat_cnt;
  logic                     stray_err;

  logic [NUM_REQ-1:0]        slot_valid;
  logic [NUM_REQ-1:0]        slot_clr;
  logic [NUM_REQ-1:0]        slot_ovf;
  logic [AXI_ADDR_WIDTH-1:0] slot_addr [NUM_REQ];
  logic [ARB_LEN_WIDTH-1:0]  slot_len  [NUM_REQ];

  logic             issue_fire;
  logic             in_wait;
  logic             any_valid;
  logic [IDX_W-1:0] pick;

  assign issue_fire = (state == ARB_ISSUE) && !dram_read_busy;
  assign in_wait    = (state == ARB_WAIT_DATA);
  assign arb_error  = {stray_err, slot_ovf};
  assign req_read_data = in_wait ? dram_read_data : '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_clr[i] = issue_fire && (owner == IDX_W'(i));
    assign req_read_busy[i] = slot_valid[i] || ((state != ARB_IDLE) && (owner == IDX_W'(i)));
    assign req_read_data_valid[i] = in_wait && dram_read_data_valid && (owner == IDX_W'(i));

    dram_req_slot #(.ADDR_W(AXI_ADDR_WIDTH)) u_slot (
      .clk       (clk_pixel),
      .rst       (dram_arbiter_reset),
      .en        (req_read_en[i]),
      .addr      (req_read_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]),
      .len       (req_read_len[i*ARB_LEN_WIDTH +: ARB_LEN_WIDTH]),
      .clr       (slot_clr[i]),
      .valid     (slot_valid[i]),
      .held_addr (slot_addr[i]),
      .held_len  (slot_len[i]),
      .overflow  (slot_ovf[i])
    );
  end

  // First valid slot at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    any_valid = 1'b0;
    pick      = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!any_valid && slot_valid[IDX_W'(idx)]) begin
        any_valid = 1'b1;
        pick      = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge dram_arbiter_reset) begin
    if (dram_arbiter_reset) begin
      state          <= ARB_IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      beat_cnt       <= '0;
      dram_read_en   <= 1'b0;
      dram_read_addr <= '0;
      dram_read_len  <= '0;
      stray_err      <= 1'b0;
    end else begin
      dram_read_en <= 1'b0;
      if (dram_read_data_valid && !in_wait) stray_err <= 1'b1;
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            owner          <= pick;
            dram_read_addr <= slot_addr[pick];
            dram_read_len  <= slot_len[pick];
            state          <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (!dram_read_busy) begin
            dram_read_en <= 1'b1;
            beat_cnt     <= '0;
            state        <= ARB_WAIT_DATA;
          end
        end
        ARB_WAIT_DATA: begin
          if (dram_read_data_valid) begin
            if (beat_cnt == dram_read_len) begin
              rr_ptr <= IDX_W'(rr_next(32'(owner), NUM_REQ));
              state  <= ARB_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed self-checking bench for dram_read_arbiter with two requesters.
module tb_dram_read_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_read_en;
  logic [NR*AW-1:0]  req_read_addr;
  logic [NR*8-1:0]   req_read_len;
  logic [NR-1:0]     req_read_busy;
  logic [NR-1:0]     req_read_data_valid;
  logic [DW-1:0]     req_read_data;
  logic [AW-1:0]     dram_read_addr;
  logic [7:0]        dram_read_len;
  logic              dram_read_en;
  logic              dram_read_busy;
  logic [DW-1:0]     dram_read_data;
  logic              dram_read_data_valid;
  logic [NR:0]       arb_error;

  int tests_run    = 0;
  int tests_failed = 0;

  dram_read_arbiter #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
    .clk_pixel            (clk),
    .dram_arbiter_reset   (rst),
    .req_read_en          (req_read_en),
    .req_read_addr        (req_read_addr),
    .req_read_len         (req_read_len),
    .req_read_busy        (req_read_busy),
    .req_read_data_valid  (req_read_data_valid),
    .req_read_data        (req_read_data),
    .dram_read_addr       (dram_read_addr),
    .dram_read_len        (dram_read_len),
    .dram_read_en         (dram_read_en),
    .dram_read_busy       (dram_read_busy),
    .dram_read_data       (dram_read_data),
    .dram_read_data_valid (dram_read_data_valid),
    .arb_error            (arb_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] m, input logic [31:0] a0, input logic [7:0] l0,
                       input logic [31:0] a1, input logic [7:0] l1);
    req_read_addr = {a1, a0};
    req_read_len  = {l1, l0};
    req_read_en   = m;
    tick();
    req_read_en   = '0;
  endtask

  task automatic beat(input logic [DW-1:0] d, output logic [1:0] strobe, output logic [DW-1:0] seen);
    dram_read_data       = d;
    dram_read_data_valid = 1'b1;
    #1;
    strobe = req_read_data_valid;
    seen   = req_read_data;
    tick();
    dram_read_data_valid = 1'b0;
  endtask

  task automatic wait_cmd(output bit found, output logic [31:0] a, output logic [7:0] l);
    found = 1'b0;
    a     = '0;
    l     = '0;
    for (int i = 0; i < 30; i++) begin
      if (dram_read_en === 1'b1) begin
        found = 1'b1;
        a     = dram_read_addr;
        l     = dram_read_len;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst                  = 1'b1;
    req_read_en          = '0;
    req_read_addr        = '0;
    req_read_len         = '0;
    dram_read_busy       = 1'b0;
    dram_read_data       = '0;
    dram_read_data_valid = 1'b0;
    tick();
    tests_run++;
    if ({dram_read_en, req_read_busy, req_read_data_valid, arb_error} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ctl: en=%b busy=%b dv=%b err=%b, required all 0",
               dram_read_en, req_read_busy, req_read_data_valid, arb_error);
    end
    tests_run++;
    if (dram_read_addr !== 32'h0 || dram_read_len !== 8'h0 || req_read_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%h len=%h, required 0", dram_read_addr, dram_read_len);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [1:0] s;
    logic [DW-1:0] d;
    pulse(2'b01, 32'h0000_1000, 8'd0, 32'h0, 8'd0);
    tests_run++;
    if (req_read_busy !== 2'b01 || dram_read_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_capture: busy=%b en=%b, required busy=01 en=0", req_read_busy, dram_read_en);
    end
    tick();
    tests_run++;
    if (dram_read_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early: en=%b, required 0", dram_read_en);
    end
    tick();
    tests_run++;
    if (dram_read_en !== 1'b1 || dram_read_addr !== 32'h0000_1000 || dram_read_len !== 8'd0) begin
      tests_failed++;
      $display("FAIL single_cmd: en=%b addr=%h len=%0d, required en=1 addr=00001000 len=0",
               dram_read_en, dram_read_addr, dram_read_len);
    end
    beat({16{32'hA5A5_0001}}, s, d);
    tests_run++;
    if (s !== 2'b01 || d !== {16{32'hA5A5_0001}}) begin
      tests_failed++;
      $display("FAIL single_beat: strobe=%b data_lsw=%h, required 01 a5a50001", s, d[31:0]);
    end
    tests_run++;
    if (req_read_busy !== 2'b00 || dram_read_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: busy=%b en=%b, required 00 0", req_read_busy, dram_read_en);
    end
  endtask

  task automatic test_round_robin();
    bit f;
    logic [31:0] a, a0, a1, exp_a;
    logic [7:0] l;
    logic [1:0] s, exp_s;
    logic [DW-1:0] d;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      a0 = 32'h0001_0000 + 32'(p) * 32'h100;
      a1 = 32'h0002_0000 + 32'(p) * 32'h100;
      pulse(2'b11, a0, 8'd0, a1, 8'd0);
      for (int g = 0; g < 2; g++) begin
        exp_a = (g == 0) ? a0 : a1;
        exp_s = (g == 0) ? 2'b01 : 2'b10;
        wait_cmd(f, a, l);
        tests_run++;
        if (!f || a !== exp_a) begin
          tests_failed++;
          $display("FAIL rr_grant p%0d g%0d: found=%0d addr=%h, required addr=%h", p, g, f, a, exp_a);
        end
        beat({16{32'(p * 2 + g)}}, s, d);
        tests_run++;
        if (s !== exp_s) begin
          tests_failed++;
          $display("FAIL rr_route p%0d g%0d: strobe=%b, required %b", p, g, s, exp_s);
        end
      end
    end
    tick();
    tests_run++;
    if (req_read_busy !== 2'b00) begin
      tests_failed++;
      $display("FAIL rr_drain: busy=%b, required 00", req_read_busy);
    end
  endtask

  task automatic test_busy_hold();
    int errs;
    int cnt0;
    logic [1:0] s;
    logic [DW-1:0] d;
    dram_read_busy = 1'b1;
    pulse(2'b01, 32'h0000_2000, 8'd7, 32'h0, 8'd0);
    tick();
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (dram_read_en !== 1'b0 || dram_read_addr !== 32'h0000_2000 || dram_read_len !== 8'd7) errs++;
      tick();
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL hold_issue: %0d bad cycles, required 0", errs);
    end
    dram_read_busy = 1'b0;
    tick();
    tests_run++;
    if (dram_read_en !== 1'b1 || dram_read_addr !== 32'h0000_2000) begin
      tests_failed++;
      $display("FAIL hold_release: en=%b addr=%h, required 1 00002000", dram_read_en, dram_read_addr);
    end
    tick();
    tests_run++;
    if (dram_read_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_pulse_width: en=%b, required 0", dram_read_en);
    end
    cnt0 = 0;
    for (int i = 0; i < 8; i++) begin
      beat({16{32'(i)}}, s, d);
      if (s === 2'b01) cnt0++;
    end
    tests_run++;
    if (cnt0 != 8 || req_read_busy !== 2'b00) begin
      tests_failed++;
      $display("FAIL hold_beats: strobes=%0d busy=%b, required 8 00", cnt0, req_read_busy);
    end
  endtask

  task automatic test_len3();
    bit f;
    logic [31:0] a;
    logic [7:0] l;
    logic [1:0] s;
    logic [DW-1:0] d;
    int c0, c1;
    pulse(2'b10, 32'h0, 8'd0, 32'h0000_3000, 8'd3);
    wait_cmd(f, a, l);
    tests_run++;
    if (!f || a !== 32'h0000_3000 || l !== 8'd3) begin
      tests_failed++;
      $display("FAIL len3_cmd: found=%0d addr=%h len=%0d, required 00003000 3", f, a, l);
    end
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 4; i++) begin
      beat({16{32'hC0DE_0000 + 32'(i)}}, s, d);
      if (s[0] === 1'b1) c0++;
      if (s[1] === 1'b1) c1++;
      if (i == 2) begin
        tests_run++;
        if (req_read_busy !== 2'b10) begin
          tests_failed++;
          $display("FAIL len3_midburst: busy=%b, required 10", req_read_busy);
        end
      end
    end
    tests_run++;
    if (c0 != 0 || c1 != 4) begin
      tests_failed++;
      $display("FAIL len3_strobes: bit0=%0d bit1=%0d, required 0 4", c0, c1);
    end
    tests_run++;
    if (req_read_busy !== 2'b00) begin
      tests_failed++;
      $display("FAIL len3_idle: busy=%b, required 00", req_read_busy);
    end
  endtask

  task automatic test_overflow();
    bit f;
    logic [31:0] a;
    logic [7:0] l;
    logic [1:0] s;
    logic [DW-1:0] d;
    int extra;
    tests_run++;
    if (arb_error !== 3'b000) begin
      tests_failed++;
      $display("FAIL ovf_pre: err=%b, required 000", arb_error);
    end
    pulse(2'b01, 32'h0000_5000, 8'd0, 32'h0, 8'd0);
    pulse(2'b01, 32'h0000_5100, 8'd0, 32'h0, 8'd0);
    tests_run++;
    if (arb_error !== 3'b001) begin
      tests_failed++;
      $display("FAIL ovf_flag: err=%b, required 001", arb_error);
    end
    wait_cmd(f, a, l);
    tests_run++;
    if (!f || a !== 32'h0000_5000) begin
      tests_failed++;
      $display("FAIL ovf_cmd: found=%0d addr=%h, required 00005000", f, a);
    end
    beat({16{32'h0BAD_F00D}}, s, d);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (dram_read_en === 1'b1) extra++;
      tick();
    end
    tests_run++;
    if (extra != 0 || req_read_busy !== 2'b00 || arb_error !== 3'b001) begin
      tests_failed++;
      $display("FAIL ovf_no_extra: cmds=%0d busy=%b err=%b, required 0 00 001", extra, req_read_busy, arb_error);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit f;
    logic [31:0] a;
    logic [7:0] l;
    logic [1:0] s;
    logic [DW-1:0] d;
    int strobes, cmds;
    pulse(2'b10, 32'h0, 8'd0, 32'h0000_4000, 8'd3);
    wait_cmd(f, a, l);
    tests_run++;
    if (!f || a !== 32'h0000_4000) begin
      tests_failed++;
      $display("FAIL rstmid_cmd: found=%0d addr=%h, required 00004000", f, a);
    end
    beat({16{32'h1111_2222}}, s, d);
    dram_read_data       = {16{32'h3333_4444}};
    dram_read_data_valid = 1'b1;
    rst                  = 1'b1;
    #1;
    tests_run++;
    if ({dram_read_en, req_read_busy, req_read_data_valid, arb_error} !== 8'h00 ||
        dram_read_addr !== 32'h0 || dram_read_len !== 8'h0 || req_read_data !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: en=%b busy=%b dv=%b err=%b addr=%h, required all 0",
               dram_read_en, req_read_busy, req_read_data_valid, arb_error, dram_read_addr);
    end
    tick();
    rst                  = 1'b0;
    dram_read_data_valid = 1'b0;
    strobes = 0;
    for (int i = 0; i < 2; i++) begin
      beat({16{32'h5555_0000 + 32'(i)}}, s, d);
      if (s !== 2'b00) strobes++;
    end
    tests_run++;
    if (strobes != 0) begin
      tests_failed++;
      $display("FAIL rstmid_strobes: %0d strobed beats, required 0", strobes);
    end
    tests_run++;
    if (arb_error !== 3'b100) begin
      tests_failed++;
      $display("FAIL rstmid_stray: err=%b, required 100", arb_error);
    end
    cmds = 0;
    for (int i = 0; i < 5; i++) begin
      if (dram_read_en === 1'b1) cmds++;
      tick();
    end
    tests_run++;
    if (cmds != 0 || req_read_busy !== 2'b00) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: cmds=%0d busy=%b, required 0 00", cmds, req_read_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_hold();
    test_len3();
    test_overflow();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
